// File: rtl/fejkon_pcie_pkg.sv
// Shared types and widths for the fejkon PCIe TX arbiter slice.
package fejkon_pcie_pkg;

  localparam int TX_DATA_W  = 256;
  localparam int TX_EMPTY_W = 2;

  // Arbiter FSM: idle (grant per packet) or locked onto one source.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_CPL = 2'd1,
    LOCK_DMA = 2'd2
  } arb_state_t;

  // Which source currently drives the TX port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPL  = 2'd1,
    GNT_DMA  = 2'd2
  } grant_t;

endpackage

// File: rtl/fejkon_pcie_tx_arb_if.sv
// Avalon-ST beat bundle (readyLatency 0) used for both TLP sources and the
// hard IP TX port.
interface fejkon_pcie_tx_arb_if;
  import fejkon_pcie_pkg::*;

  logic [TX_DATA_W-1:0]  data;
  logic                  startofpacket;
  logic                  endofpacket;
  logic [TX_EMPTY_W-1:0] empty;
  logic                  valid;
  logic                  ready;

  modport master (
    output data, startofpacket, endofpacket, empty, valid,
    input  ready
  );

  modport slave (
    input  data, startofpacket, endofpacket, empty, valid,
    output ready
  );

endinterface

// File: rtl/fejkon_pcie_tx_mux.sv
// Zero-latency 2:1 Avalon-ST beat mux; the grant selects which source's beat
// (and valid) reaches the hard IP. No grant means valid is low.
module fejkon_pcie_tx_mux
  import fejkon_pcie_pkg::*;
(
  input  grant_t                grant_i,
  input  logic [TX_DATA_W-1:0]  cpl_data_i,
  input  logic                  cpl_sop_i,
  input  logic                  cpl_eop_i,
  input  logic [TX_EMPTY_W-1:0] cpl_empty_i,
  input  logic                  cpl_valid_i,
  input  logic [TX_DATA_W-1:0]  dma_data_i,
  input  logic                  dma_sop_i,
  input  logic                  dma_eop_i,
  input  logic [TX_EMPTY_W-1:0] dma_empty_i,
  input  logic                  dma_valid_i,
  output logic [TX_DATA_W-1:0]  tx_data_o,
  output logic                  tx_sop_o,
  output logic                  tx_eop_o,
  output logic [TX_EMPTY_W-1:0] tx_empty_o,
  output logic                  tx_valid_o
);

  // Select the granted source's beat; default to the cpl beat with valid low.
  always_comb begin
    tx_data_o  = cpl_data_i;
    tx_sop_o   = cpl_sop_i;
    tx_eop_o   = cpl_eop_i;
    tx_empty_o = cpl_empty_i;
    tx_valid_o = 1'b0;
    case (grant_i)
      GNT_CPL: begin
        tx_valid_o = cpl_valid_i;
      end
      GNT_DMA: begin
        tx_data_o  = dma_data_i;
        tx_sop_o   = dma_sop_i;
        tx_eop_o   = dma_eop_i;
        tx_empty_o = dma_empty_i;
        tx_valid_o = dma_valid_i;
      end
      default: begin
        tx_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fejkon_pcie_tx_arb.sv
// Packet-granular arbiter between the completion and DMA TLP sources onto the
// single PCIe TX port. Completions win in IDLE unless DMA has been passed over
// MAX_CONSEC times in a row. Keeps per-source packet counters and a sticky
// protocol-error flag for sop-less beats offered while unlocked.
module fejkon_pcie_tx_arb
  import fejkon_pcie_pkg::*;
#(
  parameter int MAX_CONSEC = 4,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fejkon_pcie_tx_arb_if.slave  cpl,
  fejkon_pcie_tx_arb_if.slave  dma,
  fejkon_pcie_tx_arb_if.master tx_st,
  output logic                 tx_st_error,
  output logic [CNT_W-1:0]     cpl_pkt_count,
  output logic [CNT_W-1:0]     dma_pkt_count,
  output logic                 proto_err
);

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  arb_state_t       state_q;
  logic [3:0]       streak_q, streak_d;
  logic [CNT_W-1:0] cpl_cnt_q, dma_cnt_q;
  logic             proto_err_q;

  grant_t grant_s;
  logic   cpl_cand_s, dma_cand_s;
  logic   cpl_drop_s, dma_drop_s;
  logic   cpl_acc_s, dma_acc_s;

  assign cpl_cand_s = cpl.valid & cpl.startofpacket;
  assign dma_cand_s = dma.valid & dma.startofpacket;

  // Same-cycle grant: per-packet priority in IDLE, fixed source while locked.
  always_comb begin
    grant_s    = GNT_NONE;
    cpl_drop_s = 1'b0;
    dma_drop_s = 1'b0;
    if (reset) begin
      grant_s = GNT_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (dma_cand_s && (!cpl_cand_s || streak_q == MAX_C)) begin
            grant_s = GNT_DMA;
          end else if (cpl_cand_s) begin
            grant_s = GNT_CPL;
          end else begin
            // Nobody has sop, so any valid beat here is sop-less: discard it.
            cpl_drop_s = cpl.valid;
            dma_drop_s = dma.valid;
          end
        end
        LOCK_CPL: grant_s = GNT_CPL;
        LOCK_DMA: grant_s = GNT_DMA;
        default:  grant_s = GNT_NONE;
      endcase
    end
  end

  assign cpl.ready   = ((grant_s == GNT_CPL) & tx_st.ready) | cpl_drop_s;
  assign dma.ready   = ((grant_s == GNT_DMA) & tx_st.ready) | dma_drop_s;
  assign cpl_acc_s   = cpl.valid & tx_st.ready & (grant_s == GNT_CPL);
  assign dma_acc_s   = dma.valid & tx_st.ready & (grant_s == GNT_DMA);
  assign tx_st_error = 1'b0;

  fejkon_pcie_tx_mux u_mux (
    .grant_i     (grant_s),
    .cpl_data_i  (cpl.data),
    .cpl_sop_i   (cpl.startofpacket),
    .cpl_eop_i   (cpl.endofpacket),
    .cpl_empty_i (cpl.empty),
    .cpl_valid_i (cpl.valid),
    .dma_data_i  (dma.data),
    .dma_sop_i   (dma.startofpacket),
    .dma_eop_i   (dma.endofpacket),
    .dma_empty_i (dma.empty),
    .dma_valid_i (dma.valid),
    .tx_data_o   (tx_st.data),
    .tx_sop_o    (tx_st.startofpacket),
    .tx_eop_o    (tx_st.endofpacket),
    .tx_empty_o  (tx_st.empty),
    .tx_valid_o  (tx_st.valid)
  );

  // Streak of cpl wins taken while dma was waiting, saturating at MAX_C.
  always_comb begin
    streak_d = 4'd0;
    if (grant_s == GNT_CPL && dma.valid) begin
      streak_d = (streak_q == MAX_C) ? MAX_C : streak_q + 4'd1;
    end else begin
      streak_d = 4'd0;
    end
  end

  // Arbiter FSM and streak: lock on a multi-beat sop, release on its eop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpl_acc_s || dma_acc_s) streak_q <= streak_d;
          if (cpl_acc_s && !cpl.endofpacket)      state_q <= LOCK_CPL;
          else if (dma_acc_s && !dma.endofpacket) state_q <= LOCK_DMA;
          else                                    state_q <= IDLE;
        end
        LOCK_CPL: if (cpl_acc_s && cpl.endofpacket) state_q <= IDLE;
        LOCK_DMA: if (dma_acc_s && dma.endofpacket) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // Packet counters (wrap) and sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpl_cnt_q   <= '0;
      dma_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (cpl_acc_s && cpl.endofpacket) cpl_cnt_q <= cpl_cnt_q + CNT_W'(1);
      if (dma_acc_s && dma.endofpacket) dma_cnt_q <= dma_cnt_q + CNT_W'(1);
      if (cpl_drop_s || dma_drop_s)     proto_err_q <= 1'b1;
    end
  end

  assign cpl_pkt_count = cpl_cnt_q;
  assign dma_pkt_count = dma_cnt_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_fejkon_pcie_tx_arb.sv
// Self-checking bench for fejkon_pcie_tx_arb: directed corner cases plus
// randomized packet traffic, checked every cycle against a packet-level model.
module tb_fejkon_pcie_tx_arb;

  localparam int MAXC  = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [1:0]   empty;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_st_error, proto_err;
  logic [CNT_W-1:0] cpl_pkt_count, dma_pkt_count;

  fejkon_pcie_tx_arb_if cpl_if ();
  fejkon_pcie_tx_arb_if dma_if ();
  fejkon_pcie_tx_arb_if tx_if ();

  fejkon_pcie_tx_arb #(.MAX_CONSEC(MAXC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpl           (cpl_if),
    .dma           (dma_if),
    .tx_st         (tx_if),
    .tx_st_error   (tx_st_error),
    .cpl_pkt_count (cpl_pkt_count),
    .dma_pkt_count (dma_pkt_count),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source packet queues (random traffic) and the beats currently driven.
  beat_t cq[$], dq[$];
  beat_t cur_c, cur_d;
  logic  cv, dv, rdy;

  // Reference model: owner 0 = nobody, 1 = cpl, 2 = dma.
  int owner = 0, streak = 0, mcnt_c = 0, mcnt_d = 0;
  bit mperr = 1'b0, acc_c = 1'b0, acc_d = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic beat_t mk_beat(input bit sop, input bit eop);
    beat_t b;
    b.data  = rnd256();
    b.sop   = sop;
    b.eop   = eop;
    b.empty = 2'($urandom_range(3));
    return b;
  endfunction

  task automatic apply();
    cpl_if.data = cur_c.data;  cpl_if.startofpacket = cur_c.sop;
    cpl_if.endofpacket = cur_c.eop; cpl_if.empty = cur_c.empty; cpl_if.valid = cv;
    dma_if.data = cur_d.data;  dma_if.startofpacket = cur_d.sop;
    dma_if.endofpacket = cur_d.eop; dma_if.empty = cur_d.empty; dma_if.valid = dv;
    tx_if.ready = rdy;
  endtask

  // Compare DUT outputs against the packet-level rules, then advance the model.
  task automatic model_check();
    int win;
    bit cand_c, cand_d, drop_c, drop_d;
    beat_t eb;
    check("cpl_cnt", 256'(cpl_pkt_count), 256'(mcnt_c));
    check("dma_cnt", 256'(dma_pkt_count), 256'(mcnt_d));
    check("proto_err", 256'(proto_err), 256'(mperr));
    check("tx_error", 256'(tx_st_error), 256'd0);
    if (reset) begin
      check("rst_tx_valid", 256'(tx_if.valid), 256'd0);
      check("rst_cpl_ready", 256'(cpl_if.ready), 256'd0);
      check("rst_dma_ready", 256'(dma_if.ready), 256'd0);
      owner = 0; streak = 0; mcnt_c = 0; mcnt_d = 0; mperr = 1'b0;
      acc_c = 1'b0; acc_d = 1'b0;
      return;
    end
    cand_c = cv && cur_c.sop;
    cand_d = dv && cur_d.sop;
    if (owner != 0) win = owner;
    else if (cand_d && (!cand_c || streak == MAXC)) win = 2;
    else if (cand_c) win = 1;
    else win = 0;
    drop_c = (owner == 0) && (win == 0) && cv;
    drop_d = (owner == 0) && (win == 0) && dv;
    check("tx_valid", 256'(tx_if.valid), 256'((win == 1 && cv) || (win == 2 && dv)));
    check("cpl_ready", 256'(cpl_if.ready), 256'((win == 1 && rdy) || drop_c));
    check("dma_ready", 256'(dma_if.ready), 256'((win == 2 && rdy) || drop_d));
    if ((win == 1 && cv) || (win == 2 && dv)) begin
      eb = (win == 1) ? cur_c : cur_d;
      check("tx_data", tx_if.data, eb.data);
      check("tx_sop", 256'(tx_if.startofpacket), 256'(eb.sop));
      check("tx_eop", 256'(tx_if.endofpacket), 256'(eb.eop));
      check("tx_empty", 256'(tx_if.empty), 256'(eb.empty));
    end
    acc_c = (win == 1) && cv && rdy;
    acc_d = (win == 2) && dv && rdy;
    if (acc_c) begin
      if (owner == 0) begin
        streak = dv ? ((streak < MAXC) ? streak + 1 : MAXC) : 0;
        if (!cur_c.eop) owner = 1;
      end else if (cur_c.eop) owner = 0;
      if (cur_c.eop) mcnt_c = (mcnt_c + 1) % (1 << CNT_W);
    end
    if (acc_d) begin
      if (owner == 0) begin
        streak = 0;
        if (!cur_d.eop) owner = 2;
      end else if (cur_d.eop) owner = 0;
      if (cur_d.eop) mcnt_d = (mcnt_d + 1) % (1 << CNT_W);
    end
    if (drop_c || drop_d) mperr = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit c_v, input bit c_sop, input bit c_eop,
                     input bit d_v, input bit d_sop, input bit d_eop, input bit r);
    cur_c = mk_beat(c_sop, c_eop); cv = c_v;
    cur_d = mk_beat(d_sop, d_eop); dv = d_v;
    rdy = r;
    apply();
    cyc();
  endtask

  task automatic push_pkt(input int src, input int len);
    for (int i = 0; i < len; i++) begin
      if (src == 1) cq.push_back(mk_beat(i == 0, i == len - 1));
      else          dq.push_back(mk_beat(i == 0, i == len - 1));
    end
  endtask

  // One randomized cycle: retire accepted beats, refill, offer heads.
  task automatic rstep(input int cp, input int dp, input int rp, input int lc, input int ld);
    if (acc_c && cq.size() > 0) void'(cq.pop_front());
    if (acc_d && dq.size() > 0) void'(dq.pop_front());
    if (cq.size() == 0) push_pkt(1, $urandom_range(lc, 1));
    if (dq.size() == 0) push_pkt(2, $urandom_range(ld, 1));
    cv = ($urandom_range(99) < cp);
    dv = ($urandom_range(99) < dp);
    cur_c = cq[0];
    cur_d = dq[0];
    rdy = ($urandom_range(99) < rp);
    apply();
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 1, 1, 0, 1);
    reset = 1'b0;

    // Single cpl 3-beat packet; dma idle.
    drv(1, 1, 0, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 1);
    drv(1, 0, 1, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 1);

    // Collision: cpl 2-beat first, dma 2-beat waits, then goes.
    drv(1, 1, 0, 1, 1, 0, 1);
    drv(1, 0, 1, 1, 1, 0, 1);
    drv(0, 0, 0, 1, 1, 0, 1);
    drv(0, 0, 0, 1, 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 1);

    // Backpressure mid-packet on a 2-beat dma packet, cpl knocking.
    drv(0, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) drv(1, 1, 1, 1, 0, 1, 0);
    drv(1, 1, 1, 1, 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 1);

    // Starvation bound: back-to-back 1-beat cpl packets with dma waiting.
    for (int i = 0; i < 7; i++) drv(1, 1, 1, 1, 1, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 1);

    // Protocol error: sop-less cpl beat while idle, then sticky.
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1);
    drv(1, 1, 1, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of a 4-beat dma packet, then a fresh cpl sop.
    drv(0, 0, 0, 1, 1, 0, 1);
    drv(0, 0, 0, 1, 0, 0, 1);
    reset = 1'b1;
    drv(0, 0, 0, 1, 0, 0, 1);
    reset = 1'b0;
    drv(1, 1, 1, 1, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with clean state.
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 1500; i++) rstep(60, 60, 70, 4, 4);
    for (int i = 0; i < 400; i++)  rstep(100, 100, 100, 1, 3);
    for (int i = 0; i < 1200; i++) rstep(90, 50, 35, 3, 5);
    for (int i = 0; i < 600; i++)  rstep(100, 100, 80, 2, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
